// File: rtl/ifetch_unit.sv
// Instruction fetch unit: a two-state FETCH/HOLD machine that reads one
// instruction word from memory into a held instruction register, presents it
// to the decoder, and advances the PC (sequential, branch or jump) when the
// downstream stage retires it.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  npc_op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retire_cnt
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] cnt_q;
  logic [31:0] npc;
  logic        load_ir;
  logic        retire;

  // Next-PC selection; branch/jump fields always come from the held IR.
  // The reserved encoding falls through to the sequential path.
  function automatic logic [31:0] calc_npc(input logic [31:0] cur_pc,
                                           input logic [31:0] ir,
                                           input logic [1:0]  op);
    logic [31:0]        seq;
    logic signed [31:0] br_off;
    seq    = cur_pc + 32'd4;
    br_off = {{14{ir[15]}}, ir[15:0], 2'b00};
    case (op)
      2'b01:   calc_npc = seq + $unsigned(br_off);
      2'b10:   calc_npc = {seq[31:28], ir[25:0], 2'b00};
      default: calc_npc = seq;
    endcase
  endfunction

  assign npc = calc_npc(pc_q, ir_q, npc_op);

  // Next-state and handshake decode; ack in HOLD and ready in FETCH are ignored.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_ir     = 1'b0;
    retire      = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_ir = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
    endcase
  end

  // State, PC, IR and retire counter; reset wins over any handshake that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
      cnt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (load_ir) begin
        ir_q <= imem_rdata;
      end
      if (retire) begin
        pc_q  <= npc;
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign instr      = ir_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: two instances with different reset PCs share one
// stimulus stream; a transaction-level model predicts every output each cycle,
// and directed steps pin hand-computed values.
module tb_ifetch_unit;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'h3000_0004;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic [1:0]  npc_op;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, instr0, pc0, pcp40, cnt0;
  logic [31:0] addr1, instr1, pc1, pcp41, cnt1;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Model state: whether an instruction is held, its word, the retire count,
  // and the PC of each instance.
  bit          m_held;
  logic [31:0] m_ir;
  logic [31:0] m_cnt;
  logic [31:0] m_pc [2];

  ifetch_unit #(.RESET_PC(RPC0)) dut0 (
    .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr0),
    .instr_valid(valid0), .instr_ready(instr_ready), .npc_op(npc_op),
    .pc(pc0), .pc_plus4(pcp40), .retire_cnt(cnt0)
  );

  ifetch_unit #(.RESET_PC(RPC1)) dut1 (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr1),
    .instr_valid(valid1), .instr_ready(instr_ready), .npc_op(npc_op),
    .pc(pc1), .pc_plus4(pcp41), .retire_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model_npc(input logic [31:0] p,
                                            input logic [31:0] ir,
                                            input logic [1:0]  op);
    int off;
    off = $signed(ir[15:0]);
    if (op == 2'd1) return p + 32'd4 + 32'(off * 4);
    if (op == 2'd2) return ((p + 32'd4) & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 4);
    return p + 32'd4;
  endfunction

  // Model: one instruction in flight, loaded on ack, retired on ready.
  always @(posedge clk) begin
    if (rst) begin
      m_held <= 0;
      m_ir   <= 32'd0;
      m_cnt  <= 32'd0;
      m_pc[0] <= RPC0;
      m_pc[1] <= RPC1;
    end else if (!m_held && imem_ack) begin
      m_held <= 1;
      m_ir   <= imem_rdata;
    end else if (m_held && instr_ready) begin
      m_held <= 0;
      m_cnt  <= m_cnt + 32'd1;
      for (int i = 0; i < 2; i++) m_pc[i] <= model_npc(m_pc[i], m_ir, npc_op);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic req, input logic [31:0] addr,
                          input logic valid, input logic [31:0] ins, input logic [31:0] p,
                          input logic [31:0] p4, input logic [31:0] cnt);
    chk($sformatf("u%0d.imem_req", i),    {31'd0, req},   {31'd0, !m_held});
    chk($sformatf("u%0d.instr_valid", i), {31'd0, valid}, {31'd0, m_held});
    chk($sformatf("u%0d.imem_addr", i),   addr, m_pc[i]);
    chk($sformatf("u%0d.pc", i),          p,    m_pc[i]);
    chk($sformatf("u%0d.pc_plus4", i),    p4,   m_pc[i] + 32'd4);
    chk($sformatf("u%0d.instr", i),       ins,  m_ir);
    chk($sformatf("u%0d.retire_cnt", i),  cnt,  m_cnt);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, req0, addr0, valid0, instr0, pc0, pcp40, cnt0);
      cmp_inst(1, req1, addr1, valid1, instr1, pc1, pcp41, cnt1);
    end
  end

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic rdy, input logic [1:0] op);
    rst = r; imem_ack = a; imem_rdata = d; instr_ready = rdy; npc_op = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0; npc_op = 2'd0;
    drive(1, 0, 32'd0, 0, 2'd0);
    drive(1, 1, 32'h5555_5555, 1, 2'd2);
    chk_en = 1;
    chk("rst.imem_req", {31'd0, req0}, 32'd1);
    chk("rst.instr_valid", {31'd0, valid0}, 32'd0);
    chk("rst.addr0", addr0, 32'h0000_0000);
    chk("rst.addr1", addr1, 32'h3000_0004);
    chk("rst.instr", instr0, 32'd0);
    chk("rst.cnt", cnt0, 32'd0);

    // First-cycle ack, then sequential retire.
    drive(0, 1, 32'h2008_0005, 0, 2'd0);
    chk("fetch1.valid", {31'd0, valid0}, 32'd1);
    chk("fetch1.instr", instr0, 32'h2008_0005);
    chk("fetch1.pc", pc0, 32'h0000_0000);
    drive(0, 0, 32'd0, 1, 2'd0);
    chk("plus4.pc", pc0, 32'h0000_0004);
    chk("plus4.req", {31'd0, req0}, 32'd1);
    chk("plus4.cnt", cnt0, 32'd1);

    // Jump to 0x10, then backward branch to 0x0C.
    drive(0, 1, 32'h0800_0004, 0, 2'd0);
    drive(0, 0, 32'd0, 1, 2'd2);
    chk("jump.pc", pc0, 32'h0000_0010);
    drive(0, 1, 32'h1000_FFFE, 0, 2'd0);
    drive(0, 0, 32'd0, 1, 2'd1);
    chk("branch.pc", pc0, 32'h0000_000C);
    chk("branch.req", {31'd0, req0}, 32'd1);
    chk("branch.cnt", cnt0, 32'd3);

    // Slow memory, ack ignored in HOLD, slow retire with op ignored.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 32'hDEAD_BEEF, 0, 2'd1);
      chk("wait.req", {31'd0, req0}, 32'd1);
      chk("wait.addr", addr0, 32'h0000_000C);
    end
    drive(0, 1, 32'h0000_1234, 0, 2'd0);
    chk("lateack.instr", instr0, 32'h0000_1234);
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 32'hFFFF_FFFF, 0, 2'd1);
      chk("hold.instr", instr0, 32'h0000_1234);
      chk("hold.pc", pc0, 32'h0000_000C);
    end
    drive(0, 0, 32'd0, 1, 2'd0);
    chk("slowret.pc", pc0, 32'h0000_0010);
    chk("slowret.cnt", cnt0, 32'd4);

    // Reset colliding with ack, then with ready.
    drive(1, 1, 32'h0000_ABCD, 0, 2'd0);
    chk("rstack.valid", {31'd0, valid0}, 32'd0);
    chk("rstack.instr", instr0, 32'd0);
    chk("rstack.cnt", cnt0, 32'd0);
    drive(0, 1, 32'h2008_0005, 0, 2'd0);
    drive(1, 0, 32'd0, 1, 2'd2);
    chk("rstrdy.pc", pc0, 32'd0);
    chk("rstrdy.valid", {31'd0, valid0}, 32'd0);
    chk("rstrdy.instr", instr0, 32'd0);
    chk("rstrdy.cnt", cnt0, 32'd0);

    // Jump within the 0x3xxx_xxxx region on the second instance.
    drive(0, 1, 32'h0800_0040, 0, 2'd0);
    drive(0, 0, 32'd0, 1, 2'd2);
    chk("jump3.pc1", pc1, 32'h3000_0100);
    chk("jump3.pc0", pc0, 32'h0000_0100);

    // PC wrap with PLUS4 and with the reserved encoding.
    drive(1, 0, 32'd0, 0, 2'd0);
    drive(0, 1, 32'h1000_FFFE, 0, 2'd0);
    drive(0, 0, 32'd0, 1, 2'd1);
    chk("wrapA.pc", pc0, 32'hFFFF_FFFC);
    chk("wrapA.pcp4", pcp40, 32'h0000_0000);
    drive(0, 1, 32'h0000_0000, 0, 2'd0);
    drive(0, 0, 32'd0, 1, 2'd0);
    chk("wrap00.pc", pc0, 32'h0000_0000);
    drive(0, 1, 32'h1000_FFFE, 0, 2'd0);
    drive(0, 0, 32'd0, 1, 2'd1);
    drive(0, 1, 32'h1000_FFFE, 0, 2'd0);
    drive(0, 0, 32'd0, 1, 2'd3);
    chk("wrap11.pc", pc0, 32'h0000_0000);
    chk("wrap11.cnt", cnt0, 32'd4);
    drive(0, 0, 32'd0, 0, 2'd0);

    @(posedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
